// File: rtl/skid_pkg.sv
// Shared types and constants for the skid_reg elastic pipeline register.
// Optional stall counter is enabled with SKID_STALL_CNT_EN.
package skid_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL  = 2'b01,
      SKID  = 2'b10
   } skid_state_t;

   localparam int unsigned STALL_CNT_W = 16;

   // Saturating increment; holds at all-ones instead of wrapping.
   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      return (&v) ? v : v + STALL_CNT_W'(1);
   endfunction

endpackage

// File: rtl/skid_reg_en.sv
// WIDTH-bit register with load enable and synchronous active-high reset.
// Each bit is a hold/load 2:1 mux feeding a D flip-flop.
module reg_en #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DELAY = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] mux;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      // Nonzero DELAY selects the AND-OR gate form that delay back-annotation targets.
      if (DELAY == 0) begin : g_mux
         assign mux[i] = en ? d[i] : q[i];
      end else begin : g_mux
         assign mux[i] = (en & d[i]) | (~en & q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else begin
         q <= mux;
      end
   end

endmodule

// File: rtl/skid_reg.sv
// Two-entry (main + skid) elastic pipeline register with registered in_ready.
// Define SKID_STALL_CNT_EN to add the saturating stall_count output.
module skid_reg
   import skid_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DELAY = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_valid,
   input  logic                   out_ready
`ifdef SKID_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_count
`endif
);

   skid_state_t      state;
   skid_state_t      state_nxt;
   logic             main_en;
   logic             skid_en;
   logic             main_from_skid;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;

   // Next-state and register-enable decode; loads happen only on a real input word.
   always_comb begin
      state_nxt      = state;
      main_en        = 1'b0;
      skid_en        = 1'b0;
      main_from_skid = 1'b0;
      case (state)
         EMPTY: begin
            if (in_valid) begin
               main_en   = 1'b1;
               state_nxt = FULL;
            end
         end
         FULL: begin
            if (in_valid && out_ready) begin
               main_en = 1'b1;
            end else if (in_valid) begin
               skid_en   = 1'b1;
               state_nxt = SKID;
            end else if (out_ready) begin
               state_nxt = EMPTY;
            end
         end
         SKID: begin
            if (out_ready) begin
               main_en        = 1'b1;
               main_from_skid = 1'b1;
               state_nxt      = FULL;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   assign main_d = main_from_skid ? skid_q : in_data;

   // State register; handshake outputs are flops decoded from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         state     <= state_nxt;
         out_valid <= (state_nxt != EMPTY);
         in_ready  <= (state_nxt != SKID);
      end
   end

   reg_en #(.WIDTH(WIDTH), .DELAY(DELAY)) u_main (
      .clk   (clk),
      .reset (reset),
      .en    (main_en),
      .d     (main_d),
      .q     (main_q)
   );

   reg_en #(.WIDTH(WIDTH), .DELAY(DELAY)) u_skid (
      .clk   (clk),
      .reset (reset),
      .en    (skid_en),
      .d     (in_data),
      .q     (skid_q)
   );

   assign out_data = main_q;

`ifdef SKID_STALL_CNT_EN
   // Counts edges where a valid word is held back by downstream.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (out_valid && !out_ready) begin
         stall_count <= sat_inc(stall_count);
      end
   end
`endif

endmodule

// File: tb/tb_skid_reg.sv
// Self-checking bench for skid_reg: queue-based reference model plus directed literal checks.
module tb_skid_reg;

   localparam int unsigned W = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
`ifdef SKID_STALL_CNT_EN
   logic [15:0]  stall_count;
`endif

   int checks   = 0;
   int failures = 0;

   skid_reg #(.WIDTH(W), .DELAY(0)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef SKID_STALL_CNT_EN
      ,
      .stall_count (stall_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of at most two held words.
   logic [W-1:0] mq[$];
   int unsigned  m_stall = 0;
   bit           started = 1'b0;

   always @(posedge clk) begin
      bit acc_in;
      bit acc_out;
      if (reset) begin
         mq.delete();
         m_stall = 0;
         started = 1'b1;
      end else begin
         acc_in  = in_valid && (mq.size() < 2);
         acc_out = (mq.size() > 0) && out_ready;
         if ((mq.size() > 0) && !out_ready && (m_stall < 65535)) m_stall++;
         if (acc_out) void'(mq.pop_front());
         if (acc_in) mq.push_back(in_data);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
         chk("m_in_ready", 64'(in_ready), 64'(mq.size() < 2));
         if (mq.size() > 0) chk("m_out_data", out_data, mq[0]);
`ifdef SKID_STALL_CNT_EN
         chk("m_stall_count", 64'(stall_count), 64'(m_stall));
`endif
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic junk();
      in_data = {$urandom(), $urandom()};
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      repeat (2) cyc();

      // Reset then idle with garbage data on the bus
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         junk();
         cyc();
         chk("idle_out_valid", 64'(out_valid), 64'(0));
         chk("idle_in_ready", 64'(in_ready), 64'(1));
         chk("idle_out_data", out_data, 64'(0));
      end

      // Streaming at full throughput
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_data = 64'(i);
         cyc();
         chk("stream_data", out_data, 64'(i));
         chk("stream_valid", 64'(out_valid), 64'(1));
         chk("stream_in_ready", 64'(in_ready), 64'(1));
      end
      in_valid = 1'b0;
      junk();
      cyc();
      chk("stream_drain", 64'(out_valid), 64'(0));

      // Backpressure into the skid entry
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'hA;
      cyc();
      chk("bp_a_data", out_data, 64'hA);
      chk("bp_a_ready", 64'(in_ready), 64'(1));
      in_data = 64'hB;
      cyc();
      chk("bp_b_ready", 64'(in_ready), 64'(0));
      chk("bp_b_data", out_data, 64'hA);
      in_valid = 1'b0;
      junk();
      cyc();
      chk("bp_hold_data", out_data, 64'hA);
      out_ready = 1'b1;
      cyc();
      chk("bp_rel_b", out_data, 64'hB);
      chk("bp_rel_valid", 64'(out_valid), 64'(1));
      chk("bp_rel_ready", 64'(in_ready), 64'(1));
      cyc();
      chk("bp_empty", 64'(out_valid), 64'(0));

      // Simultaneous in/out while FULL
      in_valid = 1'b1;
      in_data  = 64'h5;
      cyc();
      chk("sim_main5", out_data, 64'h5);
      in_data = 64'h6;
      cyc();
      chk("sim_main6", out_data, 64'h6);
      chk("sim_valid", 64'(out_valid), 64'(1));
      chk("sim_ready", 64'(in_ready), 64'(1));
      in_valid = 1'b0;
      cyc();
      chk("sim_empty", 64'(out_valid), 64'(0));

      // Reset while SKID holds C/D; neither may be emitted
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'hC;
      cyc();
      in_data = 64'hD;
      cyc();
      chk("rst_skid_ready", 64'(in_ready), 64'(0));
      in_data = 64'hE;
      reset   = 1'b1;
      cyc();
      reset    = 1'b0;
      in_valid = 1'b0;
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_ready", 64'(in_ready), 64'(1));
      chk("rst_data", out_data, 64'(0));
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("rst_no_emit", 64'(out_valid), 64'(0));
      end

      // Mixed traffic checked by the model
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 2) != 0);
         junk();
         cyc();
      end

`ifdef SKID_STALL_CNT_EN
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      cyc();
      reset    = 1'b0;
      in_valid = 1'b1;
      in_data  = 64'h77;
      cyc();
      in_valid = 1'b0;
      chk("stall_start", 64'(stall_count), 64'(0));
      repeat (10) cyc();
      chk("stall_ten", 64'(stall_count), 64'(10));
      repeat (65530) cyc();
      chk("stall_sat", 64'(stall_count), 64'hFFFF);
      repeat (5) cyc();
      chk("stall_hold", 64'(stall_count), 64'hFFFF);
      chk("stall_data", out_data, 64'h77);
`endif

      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
